low_araddr_ar_issue: RTL

//  Read side of the low_araddr FIFO. Pops read requests {beats_m1, addr} from the FIFO.

---
 rtl/low_araddr_ar_issue.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/low_araddr_ar_issue.sv
// Read side of the low_araddr FIFO: pops {beats_m1, addr} requests and splits them into AXI4 INCR
// AR bursts of at most MAX_BURST beats, with at most MAX_OUTSTANDING bursts open. Macro: AR_4K_SPLIT_EN.
module low_araddr_ar_issue #(
    parameter int ADDR_W          = 32,
    parameter int LEN_W           = 16,
    parameter int DATA_BYTES      = 32,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 8,
    parameter int AR_ID           = 0
) (
    input  logic                    rd_clk,
    input  logic                    rd_rst,
    input  logic [LEN_W+ADDR_W-1:0] fifo_rd_data,
    input  logic                    fifo_rd_empty,
    output logic                    fifo_rd_en,
    output logic [ADDR_W-1:0]       m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic [3:0]              m_arid,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic                    m_rlast_hs,
    output logic [7:0]              outstanding,
    output logic                    busy
);

    localparam int SIZE  = $clog2(DATA_BYTES);
    localparam int REM_W = LEN_W + 1;
    // Wide enough for the remaining count and for a full 4 KB page of single-byte beats.
    localparam int CNT_W = (REM_W > 13) ? REM_W : 13;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DATA_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CALC,
        ISSUE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [REM_W-1:0]  remaining;
    logic [8:0]        cur_beats;
    logic [CNT_W-1:0]  beats;
    logic              ar_hs;
    logic              rl_dec;
    logic              can_issue;
    logic              last_burst;

    assign m_arsize  = 3'(SIZE);
    assign m_arburst = 2'b01;
    assign m_arid    = 4'(AR_ID);
    assign m_arvalid = (state == ISSUE);
    assign busy      = (state != IDLE);

    assign fifo_rd_en = (state == IDLE) && !fifo_rd_empty && !rd_rst;
    assign ar_hs      = m_arvalid && m_arready;
    assign rl_dec     = m_rlast_hs && (outstanding != 8'd0);
    assign can_issue  = (outstanding < 8'(MAX_OUTSTANDING));
    assign last_burst = (remaining == REM_W'(cur_beats));

`ifdef AR_4K_SPLIT_EN
    // Beats left before the next 4 KB page; cur_addr is always beat-aligned so this is >= 1.
    logic [CNT_W-1:0] to4k;
    assign to4k = CNT_W'((13'd4096 - {1'b0, cur_addr[11:0]}) >> SIZE);
`endif

    always_comb begin
        beats = CNT_W'(remaining);
        if (beats > CNT_W'(MAX_BURST)) begin
            beats = CNT_W'(MAX_BURST);
        end
`ifdef AR_4K_SPLIT_EN
        if (beats > to4k) begin
            beats = to4k;
        end
`endif
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fifo_rd_en) state_nxt = FETCH;
            FETCH:   state_nxt = CALC;
            CALC:    if (can_issue) state_nxt = ISSUE;
            ISSUE: begin
                if (ar_hs) state_nxt = last_burst ? IDLE : CALC;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            cur_beats <= '0;
            m_araddr  <= '0;
            m_arlen   <= '0;
        end else begin
            case (state)
                FETCH: begin
                    cur_addr  <= fifo_rd_data[ADDR_W-1:0] & ALIGN_MASK;
                    remaining <= REM_W'(fifo_rd_data[LEN_W+ADDR_W-1:ADDR_W]) + REM_W'(1);
                end
                CALC: begin
                    m_araddr  <= cur_addr;
                    m_arlen   <= 8'(beats - CNT_W'(1));
                    cur_beats <= beats[8:0];
                end
                ISSUE: begin
                    if (ar_hs) begin
                        cur_addr  <= cur_addr + (ADDR_W'(cur_beats) << SIZE);
                        remaining <= remaining - REM_W'(cur_beats);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A burst opening and another closing in the same cycle leave the count unchanged.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            outstanding <= 8'd0;
        end else begin
            case ({ar_hs, rl_dec})
                2'b10:   outstanding <= outstanding + 8'd1;
                2'b01:   outstanding <= outstanding - 8'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    ar_stable_a: assert property (@(posedge rd_clk) disable iff (rd_rst)
        (m_arvalid && !m_arready) |=> (m_arvalid && $stable(m_araddr) && $stable(m_arlen)));

    outstanding_cap_a: assert property (@(posedge rd_clk) disable iff (rd_rst)
        outstanding <= 8'(MAX_OUTSTANDING));

endmodule
